// File: rtl/axis_seq_generator.sv
// AXI4-Stream master that emits packetised numeric sequences.
// The sequence can be geometric, arithmetic, Galois-LFSR or constant.
// Mode, step and packet length are latched at every packet start.
// The seed is latched only when leaving IDLE, so back-to-back packets
// continue one unbroken sequence. All outputs come straight from registers.
module axis_seq_generator #(
  parameter int DATA_SIZE = 32,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_areset,
  input  logic                   m00_axis_enable,
  input  logic [1:0]             cfg_mode,
  input  logic [DATA_SIZE-1:0]   cfg_step,
  input  logic [DATA_SIZE-1:0]   cfg_seed,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic                   m00_axis_tready,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   pkt_count
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0] MODE_MUL   = 2'd0;
  localparam logic [1:0] MODE_ADD   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Registered state and outputs
  state_t                 state_r;
  logic [DATA_SIZE-1:0]   tdata_r;
  logic [STRB_W-1:0]      tstrb_r;
  logic                   tvalid_r;
  logic                   tlast_r;
  logic                   busy_r;
  logic [CNT_WIDTH-1:0]   pkt_count_r;
  logic [LEN_WIDTH-1:0]   beat_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [1:0]             mode_r;
  logic [DATA_SIZE-1:0]   step_r;

  // Next-state values
  state_t                 state_nxt_s;
  logic [DATA_SIZE-1:0]   tdata_nxt_s;
  logic [STRB_W-1:0]      tstrb_nxt_s;
  logic                   tvalid_nxt_s;
  logic                   tlast_nxt_s;
  logic                   busy_nxt_s;
  logic [CNT_WIDTH-1:0]   pkt_count_nxt_s;
  logic [LEN_WIDTH-1:0]   beat_nxt_s;
  logic [LEN_WIDTH-1:0]   len_nxt_s;
  logic [1:0]             mode_nxt_s;
  logic [DATA_SIZE-1:0]   step_nxt_s;

  // Helper terms
  logic                   handshake_s;
  logic                   last_beat_s;
  logic [LEN_WIDTH-1:0]   cfg_len_s;
  logic [DATA_SIZE-1:0]   seq_next_s;

  // Sequence step. Every result is truncated to DATA_SIZE bits.
  function automatic logic [DATA_SIZE-1:0] next_value(
    input logic [1:0]           mode,
    input logic [DATA_SIZE-1:0] cur,
    input logic [DATA_SIZE-1:0] step
  );
    logic [DATA_SIZE-1:0] res;
    case (mode)
      MODE_MUL:   res = cur * step;
      MODE_ADD:   res = cur + step;
      MODE_LFSR:  res = (cur >> 1) ^ (cur[0] ? step : {DATA_SIZE{1'b0}});
      MODE_CONST: res = cur;
      default:    res = cur;
    endcase
    return res;
  endfunction

  assign handshake_s = tvalid_r & m00_axis_tready;
  assign last_beat_s = (beat_r == (len_r - LEN_ONE));
  // A packet length of zero is treated as one beat.
  assign cfg_len_s   = (cfg_pkt_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : cfg_pkt_len;
  // The step uses the configuration latched for the packet being sent.
  assign seq_next_s  = next_value(mode_r, tdata_r, step_r);

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt_s     = state_r;
    tdata_nxt_s     = tdata_r;
    tstrb_nxt_s     = tstrb_r;
    tvalid_nxt_s    = tvalid_r;
    tlast_nxt_s     = tlast_r;
    pkt_count_nxt_s = pkt_count_r;
    beat_nxt_s      = beat_r;
    len_nxt_s       = len_r;
    mode_nxt_s      = mode_r;
    step_nxt_s      = step_r;

    case (state_r)
      ST_IDLE: begin
        tvalid_nxt_s = 1'b0;
        tlast_nxt_s  = 1'b0;
        tstrb_nxt_s  = {STRB_W{1'b0}};
        if (m00_axis_enable) begin
          mode_nxt_s   = cfg_mode;
          step_nxt_s   = cfg_step;
          len_nxt_s    = cfg_len_s;
          tdata_nxt_s  = cfg_seed;
          beat_nxt_s   = {LEN_WIDTH{1'b0}};
          tvalid_nxt_s = 1'b1;
          tstrb_nxt_s  = {STRB_W{1'b1}};
          tlast_nxt_s  = (cfg_len_s == LEN_ONE);
          state_nxt_s  = ST_STREAM;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if (!handshake_s) begin
          // Stall: the beat stays on the bus unchanged.
          state_nxt_s = ST_STREAM;
        end else if (!last_beat_s) begin
          tdata_nxt_s = seq_next_s;
          beat_nxt_s  = beat_r + LEN_ONE;
          tlast_nxt_s = ((beat_r + LEN_ONE) == (len_r - LEN_ONE));
        end else begin
          pkt_count_nxt_s = pkt_count_r + CNT_ONE;
          if (m00_axis_enable) begin
            // Back-to-back packet: the sequence continues and is not re-seeded.
            mode_nxt_s   = cfg_mode;
            step_nxt_s   = cfg_step;
            len_nxt_s    = cfg_len_s;
            tdata_nxt_s  = seq_next_s;
            beat_nxt_s   = {LEN_WIDTH{1'b0}};
            tlast_nxt_s  = (cfg_len_s == LEN_ONE);
            tvalid_nxt_s = 1'b1;
            state_nxt_s  = ST_STREAM;
          end else begin
            tvalid_nxt_s = 1'b0;
            tlast_nxt_s  = 1'b0;
            tstrb_nxt_s  = {STRB_W{1'b0}};
            state_nxt_s  = ST_IDLE;
          end
        end
      end

      default: begin
        // An illegal state encoding falls back to a quiet IDLE.
        state_nxt_s  = ST_IDLE;
        tvalid_nxt_s = 1'b0;
        tlast_nxt_s  = 1'b0;
        tstrb_nxt_s  = {STRB_W{1'b0}};
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers, with synchronous reset taking priority.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_r     <= ST_IDLE;
      tdata_r     <= {DATA_SIZE{1'b0}};
      tstrb_r     <= {STRB_W{1'b0}};
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      busy_r      <= 1'b0;
      pkt_count_r <= {CNT_WIDTH{1'b0}};
      beat_r      <= {LEN_WIDTH{1'b0}};
      len_r       <= LEN_ONE;
      mode_r      <= MODE_MUL;
      step_r      <= {DATA_SIZE{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      tdata_r     <= tdata_nxt_s;
      tstrb_r     <= tstrb_nxt_s;
      tvalid_r    <= tvalid_nxt_s;
      tlast_r     <= tlast_nxt_s;
      busy_r      <= busy_nxt_s;
      pkt_count_r <= pkt_count_nxt_s;
      beat_r      <= beat_nxt_s;
      len_r       <= len_nxt_s;
      mode_r      <= mode_nxt_s;
      step_r      <= step_nxt_s;
    end
  end

  assign m00_axis_tdata  = tdata_r;
  assign m00_axis_tstrb  = tstrb_r;
  assign m00_axis_tvalid = tvalid_r;
  assign m00_axis_tlast  = tlast_r;
  assign busy            = busy_r;
  assign pkt_count       = pkt_count_r;

endmodule

// File: tb/tb_axis_seq_generator.sv
// Directed self-checking bench for axis_seq_generator.
// The bench drives a 32-bit instance and an 8-bit instance from shared
// control inputs. Each instance has its own step and seed inputs.
module tb_axis_seq_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] pkt_len;
  logic        tready;
  logic [31:0] step32, seed32;
  logic [7:0]  step8, seed8;

  logic [31:0] tdata32;
  logic [3:0]  tstrb32;
  logic        tvalid32, tlast32, busy32;
  logic [15:0] cnt32;

  logic [7:0]  tdata8;
  logic [0:0]  tstrb8;
  logic        tvalid8, tlast8, busy8;
  logic [15:0] cnt8;

  int checks = 0;
  int failures = 0;

  // Free-running clock
  always #5 clk = ~clk;

  axis_seq_generator #(.DATA_SIZE(32), .LEN_WIDTH(16), .CNT_WIDTH(16)) dut32 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .m00_axis_enable(en),
    .cfg_mode(mode), .cfg_step(step32), .cfg_seed(seed32), .cfg_pkt_len(pkt_len),
    .m00_axis_tready(tready), .m00_axis_tdata(tdata32), .m00_axis_tstrb(tstrb32),
    .m00_axis_tvalid(tvalid32), .m00_axis_tlast(tlast32), .busy(busy32),
    .pkt_count(cnt32)
  );

  axis_seq_generator #(.DATA_SIZE(8), .LEN_WIDTH(16), .CNT_WIDTH(16)) dut8 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .m00_axis_enable(en),
    .cfg_mode(mode), .cfg_step(step8), .cfg_seed(seed8), .cfg_pkt_len(pkt_len),
    .m00_axis_tready(tready), .m00_axis_tdata(tdata8), .m00_axis_tstrb(tstrb8),
    .m00_axis_tvalid(tvalid8), .m00_axis_tlast(tlast8), .busy(busy8),
    .pkt_count(cnt8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; pkt_len = 16'd4; tready = 1'b1;
    step32 = 32'd3; seed32 = 32'd1; step8 = 8'd0; seed8 = 8'd0;
    tick(); tick();
    checks++;
    if (tvalid32 !== 1'b0 || tlast32 !== 1'b0 || tstrb32 !== 4'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got valid=%b last=%b strb=%h, expected 0 0 0", tvalid32, tlast32, tstrb32);
    end
    checks++;
    if (tdata32 !== 32'd0 || busy32 !== 1'b0 || cnt32 !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got data=%0h busy=%b cnt=%0d, expected 0 0 0", tdata32, busy32, cnt32);
    end
    checks++;
    if (tdata8 !== 8'd0 || tvalid8 !== 1'b0 || tstrb8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut8: got data=%0h valid=%b strb=%b, expected 0 0 0", tdata8, tvalid8, tstrb8);
    end
    rst = 1'b0;
  endtask

  task automatic test_multiply();
    logic [31:0] exp_d [8];
    exp_d = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81, 32'd243, 32'd729, 32'd2187};
    apply_reset();
    mode = 2'd0; seed32 = 32'd1; step32 = 32'd3; pkt_len = 16'd4; tready = 1'b1; en = 1'b1;
    tick();
    checks++;
    if (busy32 !== 1'b1 || tstrb32 !== 4'hF) begin
      failures++;
      $display("FAIL mul_start: got busy=%b strb=%h, expected 1 f", busy32, tstrb32);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tdata32 !== exp_d[i] || tvalid32 !== 1'b1 || tlast32 !== ((i % 4) == 3)) begin
        failures++;
        $display("FAIL mul_beat%0d: got data=%0d valid=%b last=%b, expected %0d 1 %b",
                 i, tdata32, tvalid32, tlast32, exp_d[i], ((i % 4) == 3));
      end
      tick();
    end
    checks++;
    if (cnt32 !== 16'd2 || tdata32 !== 32'd6561) begin
      failures++;
      $display("FAIL mul_count: got cnt=%0d data=%0d, expected 2 6561", cnt32, tdata32);
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    mode = 2'd0; seed32 = 32'd1; step32 = 32'd3; pkt_len = 16'd4; tready = 1'b1; en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (tdata32 !== 32'd9) begin
      failures++;
      $display("FAIL bp_pre: got data=%0d, expected 9", tdata32);
    end
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tdata32 !== 32'd9 || tvalid32 !== 1'b1 || tlast32 !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got data=%0d valid=%b last=%b, expected 9 1 0", i, tdata32, tvalid32, tlast32);
      end
    end
    tready = 1'b1;
    tick();
    checks++;
    if (tdata32 !== 32'd27 || tlast32 !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: got data=%0d last=%b, expected 27 1", tdata32, tlast32);
    end
    en = 1'b0;
    tick();
    checks++;
    if (tvalid32 !== 1'b0 || busy32 !== 1'b0 || cnt32 !== 16'd1 || tdata32 !== 32'd27) begin
      failures++;
      $display("FAIL bp_stop: got valid=%b busy=%b cnt=%0d data=%0d, expected 0 0 1 27",
               tvalid32, busy32, cnt32, tdata32);
    end
  endtask

  task automatic test_add_wrap();
    logic [7:0] exp_d [3];
    exp_d = '{8'd250, 8'd4, 8'd14};
    apply_reset();
    mode = 2'd1; seed8 = 8'd250; step8 = 8'd10; pkt_len = 16'd3; tready = 1'b1; en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tdata8 !== exp_d[i] || tlast8 !== (i == 2) || tstrb8 !== 1'b1) begin
        failures++;
        $display("FAIL add_beat%0d: got data=%0d last=%b strb=%b, expected %0d %b 1",
                 i, tdata8, tlast8, tstrb8, exp_d[i], (i == 2));
      end
      if (i == 2) en = 1'b0;
      tick();
    end
    checks++;
    if (tvalid8 !== 1'b0 || busy8 !== 1'b0 || tlast8 !== 1'b0 || tdata8 !== 8'd14 || cnt8 !== 16'd1) begin
      failures++;
      $display("FAIL add_stop: got valid=%b busy=%b last=%b data=%0d cnt=%0d, expected 0 0 0 14 1",
               tvalid8, busy8, tlast8, tdata8, cnt8);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_d [6];
    exp_d = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    apply_reset();
    mode = 2'd2; seed8 = 8'h01; step8 = 8'hB8; pkt_len = 16'd6; tready = 1'b1; en = 1'b1;
    tick();
    // Mid-packet enable and configuration changes must not disturb the packet.
    en = 1'b0; step8 = 8'hFF; mode = 2'd3; pkt_len = 16'd2;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tdata8 !== exp_d[i] || tlast8 !== (i == 5) || tvalid8 !== 1'b1) begin
        failures++;
        $display("FAIL lfsr_beat%0d: got data=%h last=%b valid=%b, expected %h %b 1",
                 i, tdata8, tlast8, tvalid8, exp_d[i], (i == 5));
      end
      tick();
    end
    checks++;
    if (tvalid8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL lfsr_stop: got valid=%b busy=%b, expected 0 0", tvalid8, busy8);
    end
  endtask

  task automatic test_len_zero();
    apply_reset();
    mode = 2'd3; seed8 = 8'hA5; step8 = 8'h11; pkt_len = 16'd0; tready = 1'b1; en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tdata8 !== 8'hA5 || tlast8 !== 1'b1 || tvalid8 !== 1'b1 || cnt8 !== 16'(k)) begin
        failures++;
        $display("FAIL len0_beat%0d: got data=%h last=%b valid=%b cnt=%0d, expected a5 1 1 %0d",
                 k, tdata8, tlast8, tvalid8, cnt8, k);
      end
      tick();
    end
    en = 1'b0;
    tick();
    checks++;
    if (cnt8 !== 16'd6 || tvalid8 !== 1'b0) begin
      failures++;
      $display("FAIL len0_end: got cnt=%0d valid=%b, expected 6 0", cnt8, tvalid8);
    end
  endtask

  task automatic test_back_to_back_reset();
    apply_reset();
    mode = 2'd0; seed32 = 32'd1; step32 = 32'd3; pkt_len = 16'd4; tready = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (tdata32 !== 32'd243 || cnt32 !== 16'd1) begin
      failures++;
      $display("FAIL rst_pre: got data=%0d cnt=%0d, expected 243 1", tdata32, cnt32);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (tvalid32 !== 1'b0 || tdata32 !== 32'd0 || cnt32 !== 16'd0 || busy32 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got valid=%b data=%0d cnt=%0d busy=%b, expected 0 0 0 0",
               tvalid32, tdata32, cnt32, busy32);
    end
    seed32 = 32'd7;
    tick();
    checks++;
    if (tvalid32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority: got valid=%b busy=%b, expected 0 0", tvalid32, busy32);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tdata32 !== 32'd7 || tvalid32 !== 1'b1) begin
      failures++;
      $display("FAIL rst_release: got data=%0d valid=%b, expected 7 1", tdata32, tvalid32);
    end
    en = 1'b0;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_multiply();
    test_backpressure();
    test_add_wrap();
    test_lfsr();
    test_len_zero();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
